matrix_inv_seq: RTL and testbench

Parametrised, handshaked successor of the combinational 2x2 fixed-point matrix inverter. It accepts a signed 2x2 matrix [[a b];[c d]] in Q(W-FRAC).FRAC format and computes the inverse (1/det)·[[d −b];[−c a]]. The reciprocal is produced by a multi-cycle restoring divider, so the block closes timing at wide W. Results are saturated, and singular and overflow conditions are flagged. It sits between a valid/ready matrix producer and a valid/ready consumer.

---
 rtl/matrix_inv_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_matrix_inv_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_inv_seq.sv
// matrix_inv_seq: sequential 2x2 signed fixed-point matrix inverter.
// Accepts [[a b];[c d]] in Q(W-FRAC).FRAC over a valid/ready handshake, computes
// the determinant, a floor reciprocal via a bit-serial restoring divider, and
// returns the saturated inverse (1/det)*[[d -b];[-c a]].
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   in_valid / in_ready            input handshake (in_ready high only in IDLE)
//   a, b, c, d                     signed input elements, W bits
//   out_valid / out_ready          output handshake (out_valid high only in DONE)
//   a_inv, b_inv, c_inv, d_inv     signed inverse elements, W bits
//   error                          singular matrix, qualified by out_valid
//   sat                            at least one output clamped, qualified by out_valid
module matrix_inv_seq #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] a_inv,
    output logic signed [W-1:0] b_inv,
    output logic signed [W-1:0] c_inv,
    output logic signed [W-1:0] d_inv,
    output logic                error,
    output logic                sat
);

    localparam int unsigned DTW = 2 * W + 1;           // full-precision determinant
    localparam int unsigned QW  = 2 * FRAC + 1;        // reciprocal quotient bits
    localparam int unsigned PW  = W + 2 * FRAC + 2;    // scale product
    localparam int unsigned CW  = $clog2(QW);          // divider step counter
    localparam logic [3:0]  NEG_MASK = 4'b0110;        // -b and -c positions

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DET   = 3'd1,
        DIV   = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic signed [W-1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic                sgn_q, sgn_d;
    logic [DTW-1:0]      dvs_q, dvs_d;
    logic [DTW-1:0]      rem_q, rem_d;
    logic [QW-1:0]       quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] a_inv_q, b_inv_q, c_inv_q, d_inv_q;
    logic signed [W-1:0] a_inv_d, b_inv_d, c_inv_d, d_inv_d;
    logic                error_q, error_d, sat_q, sat_d;
    logic                out_valid_q, out_valid_d;

    logic signed [DTW-1:0] ad_full, bc_full, det_full, det_sh;
    logic [DTW-1:0]        det_abs;
    logic                  dvd_bit, rem_ge;
    logic [DTW:0]          rem_sh;
    logic signed [W-1:0]   src   [4];
    logic [W:0]            scl   [4];

    // One output element: optional negation, multiply by R, floor shift, clamp.
    // Returns {clamped, value}.
    function automatic logic [W:0] scale_elem(
        input logic signed [W-1:0] s,
        input logic                flip,
        input logic [QW-1:0]       r
    );
        logic signed [W:0]    xe, xv;
        logic signed [PW-1:0] xp, rp, p, y;
        logic [PW-W:0]        hi;
        logic                 ovf;
        logic [W-1:0]         val;
        xe  = {s[W-1], s};
        xv  = flip ? -xe : xe;
        xp  = {{(PW-W-1){xv[W]}}, xv};
        rp  = {{(PW-QW){1'b0}}, r};
        p   = xp * rp;
        y   = p >>> FRAC;
        hi  = y[PW-1:W-1];
        ovf = !((&hi) || !(|hi));
        if (ovf) begin
            val = y[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            val = y[W-1:0];
        end
        return {ovf, val};
    endfunction

    // in_ready is a pure state decode, forced low while reset is held.
    assign in_ready  = reset_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign a_inv     = a_inv_q;
    assign b_inv     = b_inv_q;
    assign c_inv     = c_inv_q;
    assign d_inv     = d_inv_q;
    assign error     = error_q;
    assign sat       = sat_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            sgn_q       <= 1'b0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            a_inv_q     <= '0;
            b_inv_q     <= '0;
            c_inv_q     <= '0;
            d_inv_q     <= '0;
            error_q     <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            sgn_q       <= sgn_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            a_inv_q     <= a_inv_d;
            b_inv_q     <= b_inv_d;
            c_inv_q     <= c_inv_d;
            d_inv_q     <= d_inv_d;
            error_q     <= error_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        sgn_d   = sgn_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        a_inv_d = a_inv_q;
        b_inv_d = b_inv_q;
        c_inv_d = c_inv_q;
        d_inv_d = d_inv_q;
        error_d = error_q;
        sat_d   = sat_q;

        // Determinant, exact before the floor shift.
        ad_full  = {{(DTW-W){a_q[W-1]}}, a_q} * {{(DTW-W){d_q[W-1]}}, d_q};
        bc_full  = {{(DTW-W){b_q[W-1]}}, b_q} * {{(DTW-W){c_q[W-1]}}, c_q};
        det_full = ad_full - bc_full;
        det_sh   = det_full >>> FRAC;
        det_abs  = det_sh[DTW-1] ? -det_sh : det_sh;

        // Restoring divider step; the dividend 2^(2*FRAC) has a single 1 in its MSB.
        dvd_bit = (cnt_q == '0);
        rem_sh  = {rem_q, dvd_bit};
        rem_ge  = (rem_sh >= {1'b0, dvs_q});

        // Output element sources in a_inv..d_inv order.
        src[0] = d_q;
        src[1] = b_q;
        src[2] = c_q;
        src[3] = a_q;
        for (int i = 0; i < 4; i++) begin
            scl[i] = scale_elem(src[i], NEG_MASK[i] ^ sgn_q, quo_q);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    d_d     = d;
                    state_d = DET;
                end
            end
            DET: begin
                if (det_sh == '0) begin
                    a_inv_d = '0;
                    b_inv_d = '0;
                    c_inv_d = '0;
                    d_inv_d = '0;
                    error_d = 1'b1;
                    sat_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    sgn_d   = det_sh[DTW-1];
                    dvs_d   = det_abs;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = rem_ge ? DTW'(rem_sh - {1'b0, dvs_q}) : rem_sh[DTW-1:0];
                quo_d = {quo_q[QW-2:0], rem_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                a_inv_d = scl[0][W-1:0];
                b_inv_d = scl[1][W-1:0];
                c_inv_d = scl[2][W-1:0];
                d_inv_d = scl[3][W-1:0];
                sat_d   = scl[0][W] | scl[1][W] | scl[2][W] | scl[3][W];
                error_d = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_matrix_inv_seq.sv
// tb_matrix_inv_seq: directed bench for matrix_inv_seq (W=16, FRAC=14) with
// hand-computed expected inverses, latencies, backpressure and mid-divide reset.
module tb_matrix_inv_seq;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a, b, c, d;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] a_inv, b_inv, c_inv, d_inv;
    logic                error;
    logic                sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_inv_seq #(.W(16), .FRAC(14)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_inv     (a_inv),
        .b_inv     (b_inv),
        .c_inv     (c_inv),
        .d_inv     (d_inv),
        .error     (error),
        .sat       (sat)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a matrix and hold in_valid through exactly one accept edge.
    task automatic accept_mat(input string tag, input int av, input int bv,
                              input int cv, input int dv);
        a = W'(av);
        b = W'(bv);
        c = W'(cv);
        d = W'(dv);
        check_eq({tag, "_in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid, bounded.
    task automatic wait_done(input string tag, input int lat);
        int cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq({tag, "_latency"}, cnt, lat);
    endtask

    task automatic check_res(input string tag, input int ea, input int eb,
                             input int ec, input int ed, input int eerr, input int esat);
        check_eq({tag, "_out_valid"}, int'(out_valid), 1);
        check_eq({tag, "_a_inv"}, int'(a_inv), ea);
        check_eq({tag, "_b_inv"}, int'(b_inv), eb);
        check_eq({tag, "_c_inv"}, int'(c_inv), ec);
        check_eq({tag, "_d_inv"}, int'(d_inv), ed);
        check_eq({tag, "_error"}, int'(error), eerr);
        check_eq({tag, "_sat"}, int'(sat), esat);
    endtask

    // Output handshake; block returns to IDLE on the same edge.
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_post_out_valid"}, int'(out_valid), 0);
        check_eq({tag, "_post_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic run_mat(input string tag, input int av, input int bv, input int cv,
                           input int dv, input int lat, input int ea, input int eb,
                           input int ec, input int ed, input int eerr, input int esat);
        accept_mat(tag, av, bv, cv, dv);
        wait_done(tag, lat);
        check_res(tag, ea, eb, ec, ed, eerr, esat);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        d = '0;
        #1;
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_a_inv", int'(a_inv), 0);
        check_eq("rst_error", int'(error), 0);
        check_eq("rst_sat", int'(sat), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Identity
        run_mat("ident", 16384, 0, 0, 16384, 31, 16384, 0, 0, 16384, 0, 0);
        take_result("ident");
        check_eq("ident_hold_a_inv", int'(a_inv), 16384);

        // Positive determinant with one saturated element
        run_mat("mixed", 8192, 4096, 2048, 12288, 31, 32767, -11916, -5958, 23831, 0, 1);
        take_result("mixed");

        // Singular
        run_mat("sing", 1, 2, 2, 4, 1, 0, 0, 0, 0, 1, 0);
        take_result("sing");

        // Negative determinant
        run_mat("negdet", 0, 16384, 16384, 0, 31, 0, 16384, 16384, 0, 0, 0);
        take_result("negdet");

        // Backpressure: DONE holds while in_valid and inputs toggle
        run_mat("bp", 16384, 0, 0, 16384, 31, 16384, 0, 0, 16384, 0, 0);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            a = W'(i * 321);
            b = W'(-i * 17);
            c = W'(i + 5);
            d = W'(1000 - i);
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", int'(out_valid), 1);
            check_eq("bp_in_ready", int'(in_ready), 0);
            check_eq("bp_a_inv", int'(a_inv), 16384);
            check_eq("bp_b_inv", int'(b_inv), 0);
        end
        in_valid = 1'b0;
        take_result("bp");
        run_mat("bp_next", 8192, 4096, 2048, 12288, 31, 32767, -11916, -5958, 23831, 0, 1);
        take_result("bp_next");

        // Reset in the middle of the divide
        accept_mat("abort", 16384, 0, 0, 16384);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("abort_in_ready", int'(in_ready), 0);
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_a_inv", int'(a_inv), 0);
        check_eq("abort_b_inv", int'(b_inv), 0);
        check_eq("abort_sat", int'(sat), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check_eq("abort_rel_in_ready", int'(in_ready), 1);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            check_eq("abort_no_result", seen, 0);
        end
        run_mat("after_abort", 16384, 0, 0, 16384, 31, 16384, 0, 0, 16384, 0, 0);
        take_result("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
